// File: rtl/ysyx_22051468_ifetch_buf.sv
// rtl/ysyx_22051468_ifetch_buf.sv - fetch-to-decode instruction buffer with flush
// Small FIFO between IF and ID; empty head presents a NOP bubble at PC 0.
module ysyx_22051468_ifetch_buf #(
   parameter int                    WIDTH      = 64,
   parameter int                    INST_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [INST_WIDTH-1:0] NOP        = 32'h00000013
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [INST_WIDTH-1:0]    inst_i,
   input  logic [WIDTH-1:0]         inst_i_addr,
   output logic [WIDTH-1:0]         addr_2rom,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INST_WIDTH-1:0]    inst_o,
   output logic [WIDTH-1:0]         inst_o_addr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [INST_WIDTH-1:0] mem_inst [DEPTH];
   logic [WIDTH-1:0]      mem_addr [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  push;
   logic                  pop;

   assign addr_2rom = inst_i_addr;

   // Full blocks acceptance even when the head is leaving this cycle.
   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);

   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   assign inst_o      = out_valid ? mem_inst[rd_ptr] : NOP;
   assign inst_o_addr = out_valid ? mem_addr[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately unreset; stale entries are hidden by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst[wr_ptr] <= inst_i;
         mem_addr[wr_ptr] <= inst_i_addr;
      end
   end

endmodule

// File: tb/tb_ysyx_22051468_ifetch_buf.sv
// tb/tb_ysyx_22051468_ifetch_buf.sv - randomized and directed bench for the fetch buffer
module tb_ysyx_22051468_ifetch_buf;

   localparam int W     = 64;
   localparam int IW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP_I = 32'h00000013;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IW-1:0] inst_i = '0;
   logic [W-1:0]  inst_i_addr = '0;
   logic [W-1:0]  addr_2rom;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [IW-1:0] inst_o;
   logic [W-1:0]  inst_o_addr;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_err    = 0;

   // Reference contents, head at index 0: {pc, instruction}.
   logic [W+IW-1:0] q[$];

   ysyx_22051468_ifetch_buf #(.WIDTH(W), .INST_WIDTH(IW), .DEPTH(DEPTH), .NOP(NOP_I)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .inst_i(inst_i), .inst_i_addr(inst_i_addr), .addr_2rom(addr_2rom),
      .out_valid(out_valid), .out_ready(out_ready), .inst_o(inst_o),
      .inst_o_addr(inst_o_addr), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) q.delete();
      else if (flush) q.delete();
      else if (in_valid && q.size() < DEPTH) begin
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         q.push_back({inst_i_addr, inst_i});
      end else if (q.size() != 0 && out_ready) begin
         void'(q.pop_front());
      end
   end

   always @(negedge clk) begin
      check("m_addr_2rom", addr_2rom, inst_i_addr);
      check("m_count", 64'(count), 64'(q.size()));
      check("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("m_in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      if (q.size() != 0) begin
         check("m_inst_o", 64'(inst_o), 64'(q[0][IW-1:0]));
         check("m_inst_o_addr", inst_o_addr, q[0][W+IW-1:IW]);
      end else begin
         check("m_inst_o_nop", 64'(inst_o), 64'(NOP_I));
         check("m_inst_o_addr0", inst_o_addr, 64'd0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
      in_valid = v; inst_i = ins; inst_i_addr = pc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, expected finish before 2000000");
      $fatal(1);
   end

   initial begin
      cyc(); cyc();
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_count", 64'(count), 64'd0);
      check("reset_inst_o", 64'(inst_o), 64'(NOP_I));
      rst = 1'b0;
      cyc();

      // Single push, head held while out_ready stays low.
      drive(1'b1, 32'h00100093, 64'h80000000);
      cyc();
      drive(1'b0, 32'h0, 64'h0);
      for (int i = 0; i < 3; i++) begin
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_inst_o", 64'(inst_o), 64'h00100093);
         check("hold_inst_o_addr", inst_o_addr, 64'h80000000);
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      check("single_drained", 64'(count), 64'd0);

      // Fill to full, reject a fifth entry, then drain in order.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h1000 + i, 64'h100 + 4 * i);
         cyc();
      end
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 32'h1004, 64'h110);
      cyc();
      check("fifth_rejected", 64'(count), 64'd4);
      drive(1'b0, 32'h0, 64'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_order", inst_o_addr, 64'h100 + 4 * i);
         cyc();
      end
      check("drain_empty", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // Steady state at two entries with simultaneous push and pop.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h2000 + i, 64'h200 + 4 * i);
         cyc();
      end
      out_ready = 1'b1;
      for (int i = 2; i < 12; i++) begin
         drive(1'b1, 32'h2000 + i, 64'h200 + 4 * i);
         check("stream_count", 64'(count), 64'd2);
         check("stream_order", inst_o_addr, 64'h200 + 4 * (i - 2));
         cyc();
      end
      drive(1'b0, 32'h0, 64'h0);
      out_ready = 1'b0;

      // Flush at three entries with a concurrent push.
      flush = 1'b1; cyc(); flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h3000 + i, 64'h300 + 4 * i);
         cyc();
      end
      check("preflush_count", 64'(count), 64'd3);
      flush = 1'b1;
      drive(1'b1, 32'h3003, 64'h30c);
      cyc();
      flush = 1'b0;
      drive(1'b0, 32'h0, 64'h0);
      check("flush_count", 64'(count), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      cyc();
      check("flush_input_absent", 64'(count), 64'd0);

      // Asynchronous reset in the middle of a cycle with three entries held.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h4000 + i, 64'h400 + 4 * i);
         cyc();
      end
      drive(1'b0, 32'h0, 64'h0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      check("async_rst_inst_o", 64'(inst_o), 64'h00000013);
      check("async_rst_inst_o_addr", inst_o_addr, 64'd0);
      check("async_rst_count", 64'(count), 64'd0);
      cyc();
      rst = 1'b0;

      // Randomized traffic checked every cycle against the queue model.
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 99) < 70, $urandom, {$urandom, $urandom});
         out_ready = ($urandom_range(0, 99) < 60);
         flush = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b1;
            cyc();
            rst = 1'b0;
         end else begin
            cyc();
         end
      end
      flush = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
